// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcodes, FSM state encoding, flag bit indices.
package seq_alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_ZERO    = 0;
    localparam int unsigned FLAG_CARRY   = 1;
    localparam int unsigned FLAG_OVF     = 2;
    localparam int unsigned FLAG_DZ      = 3;
    localparam int unsigned FLAG_ILLEGAL = 4;
    localparam int unsigned NUM_FLAGS    = 5;

    // MUL and DIV are the only opcodes with both upper bits set
    function automatic logic is_muldiv(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu operand/result handshake bundle. The master side presents operands and
// consumes results; the slave side is the ALU.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;
    logic             flag_dz;
    logic             flag_illegal;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, result_hi,
        input  flag_zero, flag_carry, flag_ovf, flag_dz, flag_illegal
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, result_hi,
        output flag_zero, flag_carry, flag_ovf, flag_dz, flag_illegal
    );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// start loads the operands; one step per cycle follows for WIDTH cycles. done is
// high during the cycle that computes the final step, and lo_next/hi_next carry
// that step's result so the caller can register it on the same edge.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             run_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   sum;

    assign done    = run_q && (cnt_q == CW'(WIDTH - 1));
    assign lo_next = lo_d;
    assign hi_next = hi_d;

    // One iteration: hi holds partial product / remainder, lo holds multiplier / quotient
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        if (div_q) begin
            // b == 0 always "fits": quotient fills with ones and a shifts into hi
            if (!trial[WIDTH]) begin
                hi_d = trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Operand load, iteration counter and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            div_q <= is_div;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
        end else if (run_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result/flags. Logic and add/sub ops
// finish one cycle after acceptance; MUL/DIV run on an iterative unit for WIDTH
// cycles when SEQ_ALU_MULDIV_EN is defined, otherwise they report flag_illegal.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic  clk,
    input logic  rst_n,
    seq_alu_if.slave bus
);
    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic                   accept;
    logic [WIDTH-1:0]       alu_res;
    logic [NUM_FLAGS-1:0]   alu_flags;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         diff;

    assign accept = bus.in_valid && (state_q == ST_IDLE);

`ifdef SEQ_ALU_MULDIV_EN
    logic             div_q;
    logic             dz_q;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    assign md_start = accept && is_muldiv(bus.op);

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (md_start),
        .is_div  (bus.op[0]),
        .a       (bus.a),
        .b       (bus.b),
        .done    (md_done),
        .lo_next (md_lo),
        .hi_next (md_hi)
    );

    // Remember which iterative op is in flight and whether it divides by zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= 1'b0;
            dz_q  <= 1'b0;
        end else if (md_start) begin
            div_q <= bus.op[0];
            dz_q  <= (bus.b == '0);
        end
    end
`endif

    // Single-cycle datapath straight from the presented operands
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = {1'b0, bus.a} - {1'b0, bus.b};
        case (bus.op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_XNOR: alu_res = ~(bus.a ^ bus.b);
            OP_ADD: begin
                alu_res               = sum[WIDTH-1:0];
                alu_flags[FLAG_CARRY] = sum[WIDTH];
                alu_flags[FLAG_OVF]   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                        (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res               = diff[WIDTH-1:0];
                alu_flags[FLAG_CARRY] = diff[WIDTH];
                alu_flags[FLAG_OVF]   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                        (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            // MUL/DIV only land here when the iterative unit is absent
            default: alu_flags[FLAG_ILLEGAL] = 1'b1;
        endcase
        if (!alu_flags[FLAG_ILLEGAL]) begin
            alu_flags[FLAG_ZERO] = (alu_res == '0);
        end
    end

    // FSM next state and output-register loads
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        flags_d  = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
                    if (is_muldiv(bus.op)) begin
                        state_d = ST_BUSY;
                    end else begin
                        result_d = alu_res;
                        hi_d     = '0;
                        flags_d  = alu_flags;
                        state_d  = ST_DONE;
                    end
`else
                    result_d = alu_res;
                    hi_d     = '0;
                    flags_d  = alu_flags;
                    state_d  = ST_DONE;
`endif
                end
            end
            ST_BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
                if (md_done) begin
                    result_d            = md_lo;
                    hi_d                = md_hi;
                    flags_d             = '0;
                    flags_d[FLAG_ZERO]  = (md_lo == '0);
                    flags_d[FLAG_OVF]   = !div_q && (md_hi != '0);
                    flags_d[FLAG_DZ]    = div_q && dz_q;
                    state_d             = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.result       = result_q;
    assign bus.result_hi    = hi_q;
    assign bus.flag_zero    = flags_q[FLAG_ZERO];
    assign bus.flag_carry   = flags_q[FLAG_CARRY];
    assign bus.flag_ovf     = flags_q[FLAG_OVF];
    assign bus.flag_dz      = flags_q[FLAG_DZ];
    // Never set when the iterative unit is present, so it is constant 0 there
    assign bus.flag_illegal = flags_q[FLAG_ILLEGAL];

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16. Flags are compared as
// {zero, carry, ovf, dz, illegal}.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] flags_now();
        return {bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz, bus.flag_illegal};
    endfunction

    // Present one op from IDLE; lat = edges from acceptance to out_valid, -1 on timeout
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          output int lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op = op;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL reset_hs: got valid=%b ready=%b, required 0/1",
                     bus.out_valid, bus.in_ready);
        else passes++;
        checks++;
        if ({bus.result, bus.result_hi, flags_now()} !== 37'd0)
            $display("FAIL reset_out: got res=%h hi=%h flags=%b, required all 0",
                     bus.result, bus.result_hi, flags_now());
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_logic();
        logic [2:0]  ops [5]  = '{OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_AND};
        logic [15:0] av  [5]  = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h00FF};
        logic [15:0] bv  [5]  = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        logic [15:0] ex  [5]  = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'hF00F, 16'h0000};
        logic [4:0]  exf [5]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b10000};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(av[i], bv[i], ops[i], lat);
            checks++;
            if (lat != 1 || bus.result !== ex[i] || bus.result_hi !== 16'h0 ||
                flags_now() !== exf[i])
                $display("FAIL logic_%0d: got lat=%0d res=%h hi=%h flags=%b, required 1 %h 0000 %b",
                         i, lat, bus.result, bus.result_hi, flags_now(), ex[i], exf[i]);
            else passes++;
            consume();
        end
    endtask

    task automatic test_addsub();
        logic [2:0]  ops [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
        logic [15:0] av  [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
        logic [15:0] bv  [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0002};
        logic [15:0] ex  [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic [4:0]  exf [4] = '{5'b11000, 5'b00100, 5'b00100, 5'b01000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], ops[i], lat);
            checks++;
            if (lat != 1 || bus.result !== ex[i] || bus.result_hi !== 16'h0 ||
                flags_now() !== exf[i])
                $display("FAIL addsub_%0d: got lat=%0d res=%h hi=%h flags=%b, required 1 %h 0000 %b",
                         i, lat, bus.result, bus.result_hi, flags_now(), ex[i], exf[i]);
            else passes++;
            consume();
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
                $display("FAIL addsub_release_%0d: got ready=%b valid=%b, required 1/0",
                         i, bus.in_ready, bus.out_valid);
            else passes++;
        end
    endtask

    task automatic test_muldiv();
`ifdef SEQ_ALU_MULDIV_EN
        logic [2:0]  ops [4] = '{OP_MUL, OP_MUL, OP_DIV, OP_DIV};
        logic [15:0] av  [4] = '{16'h1234, 16'hFFFF, 16'd100, 16'd5};
        logic [15:0] bv  [4] = '{16'h0100, 16'hFFFF, 16'd7, 16'd0};
        logic [15:0] ex  [4] = '{16'h3400, 16'h0001, 16'd14, 16'hFFFF};
        logic [15:0] exh [4] = '{16'h0012, 16'hFFFE, 16'd2, 16'd5};
        logic [4:0]  exf [4] = '{5'b00100, 5'b00100, 5'b00000, 5'b00010};
        int          exl     = 17;
`else
        logic [2:0]  ops [4] = '{OP_MUL, OP_DIV, OP_MUL, OP_DIV};
        logic [15:0] av  [4] = '{16'd3, 16'd100, 16'h1234, 16'd5};
        logic [15:0] bv  [4] = '{16'd4, 16'd7, 16'h0100, 16'd0};
        logic [15:0] ex  [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] exh [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
        logic [4:0]  exf [4] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001};
        int          exl     = 1;
`endif
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], ops[i], lat);
            checks++;
            if (lat != exl || bus.result !== ex[i] || bus.result_hi !== exh[i] ||
                flags_now() !== exf[i])
                $display("FAIL muldiv_%0d: got lat=%0d res=%h hi=%h flags=%b, required %0d %h %h %b",
                         i, lat, bus.result, bus.result_hi, flags_now(), exl, ex[i], exh[i],
                         exf[i]);
            else passes++;
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(16'h0003, 16'h0004, OP_ADD, lat);
        @(negedge clk);
        bus.a = 16'h00FF; bus.b = 16'h0F0F; bus.op = OP_XOR; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.result, flags_now()} !== {2'b10, 16'h0007, 5'b0})
                $display("FAIL bp_hold_%0d: got valid=%b ready=%b res=%h flags=%b, required 1 0 0007 00000",
                         i, bus.out_valid, bus.in_ready, bus.result, flags_now());
            else passes++;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL bp_release: got ready=%b valid=%b, required 1/0",
                     bus.in_ready, bus.out_valid);
        else passes++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 16'h0FF0)
            $display("FAIL bp_accept: got valid=%b res=%h, required 1 0ff0",
                     bus.out_valid, bus.result);
        else passes++;
        consume();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.a = 16'd1; bus.b = 16'd1; bus.op = OP_ADD;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== ((i % 2) == 0) ||
                ((i % 2) == 0 && bus.result !== ((i == 0) ? 16'd2 : 16'd6)))
                $display("FAIL b2b_%0d: got valid=%b res=%h, required valid=%b res=%h",
                         i, bus.out_valid, bus.result, ((i % 2) == 0),
                         (i == 0) ? 16'd2 : 16'd6);
            else passes++;
            if (i == 0) bus.a = 16'd5;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
`ifdef SEQ_ALU_MULDIV_EN
        @(negedge clk);
        bus.a = 16'd100; bus.b = 16'd7; bus.op = OP_DIV; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
`else
        run_op(16'h1200, 16'h0034, OP_XOR, lat);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.result, bus.result_hi, flags_now()} !== 38'd0 ||
            bus.in_ready !== 1'b1)
            $display("FAIL rst_mid: got valid=%b ready=%b res=%h hi=%h flags=%b, required 0 1 0 0 0",
                     bus.out_valid, bus.in_ready, bus.result, bus.result_hi, flags_now());
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd2, 16'd3, OP_ADD, lat);
        checks++;
        if (lat != 1 || bus.result !== 16'd5 || flags_now() !== 5'b0)
            $display("FAIL rst_after_add: got lat=%0d res=%h flags=%b, required 1 0005 00000",
                     lat, bus.result, flags_now());
        else passes++;
        consume();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        test_reset();
        test_logic();
        test_addsub();
        test_muldiv();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the team's 16-bit combinational ALU. It keeps the same 3-bit opcode set but adds:
- registered outputs and status flags;
- a full-width multiply high word and a divide remainder;
- iterative multi-cycle MUL/DIV.

It sits between the operand/decode stage and writeback, and decouples both sides with valid/ready.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- op  in  3  000 AND, 001 OR, 010 XOR, 011 XNOR, 100 ADD, 101 SUB, 110 MUL, 111 DIV.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  primary result (MUL low word, DIV quotient).
- result_hi  out  WIDTH  MUL high word; DIV remainder; 0 for all other ops.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  ADD carry-out; SUB borrow (a < b); 0 otherwise.
- flag_ovf  out  1  ADD/SUB signed overflow; MUL result_hi != 0; 0 otherwise.
- flag_dz  out  1  DIV with b == 0.
- flag_illegal  out  1  MUL/DIV issued with the mul/div unit compiled out.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch a, b and op.
  - Ops 000..101: go to DONE.
  - Ops 110/111: go to BUSY and clear the iteration counter.
- BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle. After WIDTH steps, go to DONE.
- DONE: out_valid = 1. All outputs are held stable until out_ready. On out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. in_valid is ignored there and does not queue.
- Arithmetic:
  - ADD/SUB use a WIDTH+1-bit internal sum.
  - MUL produces a 2*WIDTH-bit product split into result_hi:result.
  - DIV is unsigned.
- Divide by zero: quotient = all ones, remainder = a, flag_dz = 1. It still takes WIDTH BUSY cycles so latency is data-independent.
- Reset (any state, including mid-BUSY): state = IDLE; out_valid = 0; result, result_hi and all flags = 0; counter = 0. In-flight work is discarded.

## Timing
- Accept at edge N. Result latency from acceptance:

| Ops | out_valid high from edge | Latency |
|---|---|---|
| 000..101 | N+1 | 1 cycle |
| MUL/DIV | N+1+WIDTH | WIDTH+1 cycles (17 for WIDTH=16) |

- If out_ready is high while out_valid is high at edge M, in_ready is high after edge M. The next accept is possible at edge M+1.
- Peak throughput is one op per 2 cycles (single-cycle ops with out_ready tied high).
- All outputs are registered. There is no combinational path from any input to any output except none; in_ready is decoded from state only.

## Configuration
- SEQ_ALU_MULDIV_EN defined: MUL/DIV are executed by the iterative unit as described above.
- SEQ_ALU_MULDIV_EN undefined:
  - The iterative unit and the BUSY state are not built.
  - Ops 110/111 go straight to DONE with result = 0, result_hi = 0, flag_illegal = 1, and all other flags 0.
  - flag_illegal is tied 0 when the macro is defined.

## Structure
- Package seq_alu_pkg:
  - opcode localparams (OP_AND..OP_DIV);
  - state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - the flag bit-index constants.
- Sub-module seq_alu_muldiv:
  - holds the iterative multiply/divide datapath;
  - has its own start/done handshake, the counter, and the shift registers.
  - It is instantiated only under SEQ_ALU_MULDIV_EN.
- Top level holds the FSM, the single-cycle logic/add/sub datapath, the output registers and the flag generation.

## Test plan
- ADD a=0xFFFF b=0x0001 (WIDTH=16) -> out_valid 1 cycle after accept; result 0x0000, carry 1, zero 1, ovf 0.
- SUB a=0x8000 b=0x0001 -> result 0x7FFF, ovf 1, carry 0. SUB a=0x0001 b=0x0002 -> result 0xFFFF, carry 1.
- MUL a=0x1234 b=0x0100 -> out_valid 17 cycles after accept; result 0x3400, result_hi 0x0012, ovf 1.
- DIV a=100 b=7 -> result 14, result_hi 2. DIV a=5 b=0 -> result 0xFFFF, result_hi 5, dz 1, still 17-cycle latency.
- Backpressure:
  - Stimulus: hold out_ready low 3 cycles after out_valid while driving in_valid with a new op.
  - Response: outputs unchanged, in_ready 0, new op not accepted. It is accepted only on the cycle after out_ready.
- Reset and build variants:
  - Assert rst_n=0 on the 5th BUSY cycle of a DIV -> next cycle out_valid 0, all outputs 0. After release, in_ready 1 and a fresh ADD completes normally.
  - Build without SEQ_ALU_MULDIV_EN: MUL a=3 b=4 -> result 0 with flag_illegal 1 after 1 cycle.
